// File: rtl/hi_xcorr_ssp_rx_pkg.sv
// Shared constants and types for the xcorr SSP receiver.
//   SSP_BYTE_BITS  - bits per serial byte on the SSP stream
//   phase_e        - which half of an I/Q pair the next complete byte fills
//   FRAME_ERR_MAX  - saturation value of the framing-error counter
//   pair_t         - one I/Q correlation pair as stored in the FIFO
package hi_xcorr_ssp_rx_pkg;

    localparam int SSP_BYTE_BITS = 8;

    typedef enum logic {
        PHASE_I = 1'b0,
        PHASE_Q = 1'b1
    } phase_e;

    localparam logic [7:0] FRAME_ERR_MAX = 8'hFF;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
    } pair_t;

endpackage

// File: rtl/xcorr_pair_fifo.sv
// Show-ahead FIFO holding I/Q pairs.
//   clk_i/rst_ni  clock, asynchronous active-low reset
//   flush_i       empties the FIFO and clears overflow; wins over push/pop
//   push_i        write wdata_i (dropped and flagged when full with no pop)
//   wdata_i       pair to write
//   pop_i         consumer ready; pops the head when valid_o is high
//   rdata_o       head entry (zero while empty)
//   valid_o       head holds data
//   level_o       registered occupancy 0..DEPTH
//   overflow_o    sticky: a push was dropped
// Handshake: a transfer happens on a clock edge where valid_o && pop_i;
// rdata_o is stable while valid_o is high and pop_i is low.
module xcorr_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, level_q;
    logic             overflow_q;
    logic             empty, full, do_pop, do_push;

    // Extra wrap bit separates full (same index, different lap) from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty && !flush_i;
    // A pop frees the slot in the same edge, so push-while-full succeeds then.
    assign do_push = push_i && (!full || do_pop) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE;
            if (do_push && !do_pop)      level_q <= level_q + ONE;
            else if (do_pop && !do_push) level_q <= level_q - ONE;
            if (push_i && !do_push) overflow_q <= 1'b1;
        end
    end

    assign rdata_o    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o    = !empty;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/hi_xcorr_ssp_rx.sv
// Receiver for the xcorr SSP stream. Oversamples ssp_clk/ssp_frame/ssp_din on
// ck_1356meg, deserialises MSB-first bytes on each ssp_clk falling edge, pairs
// consecutive bytes into I/Q and queues them in a show-ahead FIFO.
//   ck_1356meg, reset_n           clock and asynchronous active-low reset
//   ssp_clk, ssp_frame, ssp_din   asynchronous serial input
//   resync                        flush FIFO, restart at I phase, clear flags
//   pair_valid/pair_ready         output handshake (transfer on valid&&ready)
//   corr_i, corr_q                head pair, two's complement
//   fifo_level                    occupancy
//   overflow                      sticky pair-dropped flag
//   frame_err                     saturating framing-error count
module hi_xcorr_ssp_rx
    import hi_xcorr_ssp_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         ck_1356meg,
    input  logic                         reset_n,
    input  logic                         ssp_clk,
    input  logic                         ssp_frame,
    input  logic                         ssp_din,
    input  logic                         resync,
    output logic                         pair_valid,
    input  logic                         pair_ready,
    output logic [7:0]                   corr_i,
    output logic [7:0]                   corr_q,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic [7:0]                   frame_err
);

    localparam logic [2:0] LAST_BIT = 3'(SSP_BYTE_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, frame_sync_q, din_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, frame_s, din_s, fall;

    logic [2:0] bit_cnt_q;
    logic [6:0] shreg_q;
    logic [7:0] i_hold_q;
    logic [7:0] frame_err_q;
    phase_e     phase_q;
    logic       push_q;
    pair_t      pair_q;
    pair_t      head;
    logic [7:0] byte_d;

    always_ff @(posedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= '0;
            frame_sync_q <= '0;
            din_sync_q   <= '0;
            clk_prev_q   <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ssp_clk};
            frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], ssp_frame};
            din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], ssp_din};
            clk_prev_q   <= clk_s;
        end
    end

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign frame_s = frame_sync_q[SYNC_STAGES-1];
    assign din_s   = din_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q && !clk_s;
    // Completed byte when the current bit is the last one.
    assign byte_d  = {shreg_q, din_s};

    // Deserialiser and I/Q pairing. bit_cnt_q==0 means idle (no byte open).
    always_ff @(posedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            i_hold_q    <= '0;
            frame_err_q <= '0;
            phase_q     <= PHASE_I;
            push_q      <= 1'b0;
            pair_q      <= '0;
        end else begin
            push_q <= 1'b0;
            if (resync) begin
                bit_cnt_q   <= '0;
                phase_q     <= PHASE_I;
                frame_err_q <= '0;
            end else if (fall) begin
                if (frame_s) begin
                    shreg_q   <= {6'b0, din_s};
                    bit_cnt_q <= 3'd1;
                    // A frame marker inside an open byte: the partial byte is
                    // lost and pairing realigns on the new byte.
                    if (bit_cnt_q != '0) begin
                        phase_q <= PHASE_I;
                        if (frame_err_q != FRAME_ERR_MAX) begin
                            frame_err_q <= frame_err_q + 8'd1;
                        end
                    end
                end else if (bit_cnt_q != '0) begin
                    shreg_q <= byte_d[6:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        if (phase_q == PHASE_I) begin
                            i_hold_q <= byte_d;
                            phase_q  <= PHASE_Q;
                        end else begin
                            pair_q  <= '{i: i_hold_q, q: byte_d};
                            push_q  <= 1'b1;
                            phase_q <= PHASE_I;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
            end
        end
    end

    xcorr_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_i      (ck_1356meg),
        .rst_ni     (reset_n),
        .flush_i    (resync),
        .push_i     (push_q),
        .wdata_i    (pair_q),
        .pop_i      (pair_ready),
        .rdata_o    (head),
        .valid_o    (pair_valid),
        .level_o    (fifo_level),
        .overflow_o (overflow)
    );

    assign corr_i    = head.i;
    assign corr_q    = head.q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hi_xcorr_ssp_rx.sv
// Bench for hi_xcorr_ssp_rx. Inputs change 2 ns after a rising clock edge;
// the model advances and outputs are compared on every falling edge.
module tb_hi_xcorr_ssp_rx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ssp_clk = 1'b0;
    logic       ssp_frame = 1'b0;
    logic       ssp_din = 1'b0;
    logic       resync = 1'b0;
    logic       pair_ready = 1'b0;
    logic       pair_valid;
    logic [7:0] corr_i, corr_q;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] frame_err;

    hi_xcorr_ssp_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .ck_1356meg (clk),
        .reset_n    (reset_n),
        .ssp_clk    (ssp_clk),
        .ssp_frame  (ssp_frame),
        .ssp_din    (ssp_din),
        .resync     (resync),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .corr_i     (corr_i),
        .corr_q     (corr_q),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rdy_s = 1'b0, rs_s = 1'b0, rst_s = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_s <= pair_ready;
        rs_s  <= resync;
        rst_s <= reset_n;
    end

    // ---------------- counters / check ----------------
    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [15:0] got, logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        bit frame;
        bit din;
    } ev_t;

    ev_t         ev_q[$];     // serial bits in flight, with the cycle they land
    logic [15:0] exp_q[$];    // expected FIFO contents, head first
    bit          m_ovf;
    int          m_ferr;
    int          m_nbits;     // bits of the open byte, 0 = none open
    int          m_acc;
    bit          m_want_q;    // next complete byte is the Q half
    logic [7:0]  m_ihold;
    bit          m_pend;
    logic [15:0] m_pend_pair;

    function automatic void model_clear();
        ev_q.delete();
        exp_q.delete();
        m_ovf = 0; m_ferr = 0; m_nbits = 0; m_acc = 0;
        m_want_q = 0; m_ihold = '0; m_pend = 0; m_pend_pair = '0;
    endfunction

    function automatic void model_bit(bit f, bit d);
        logic [7:0] b;
        if (f) begin
            if (m_nbits != 0) begin
                if (m_ferr < 255) m_ferr++;
                m_want_q = 0;
            end
            m_acc   = int'(d);
            m_nbits = 1;
        end else if (m_nbits != 0) begin
            m_acc = m_acc * 2 + int'(d);
            m_nbits++;
            if (m_nbits == 8) begin
                m_nbits = 0;
                b = m_acc[7:0];
                if (!m_want_q) begin
                    m_ihold  = b;
                    m_want_q = 1;
                end else begin
                    m_pend      = 1;
                    m_pend_pair = {m_ihold, b};
                    m_want_q    = 0;
                end
            end
        end
    endfunction

    // ---------------- model step + scoreboard compare ----------------
    always @(negedge clk) begin
        bit pop;
        if (reset_n && rst_s) begin
            if (rs_s) begin
                exp_q.delete();
                m_ovf = 0; m_ferr = 0; m_nbits = 0; m_want_q = 0; m_pend = 0;
                if (ev_q.size() > 0 && ev_q[0].due == cyc) void'(ev_q.pop_front());
            end else begin
                pop = rdy_s && (exp_q.size() > 0);
                if (m_pend && pop) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(m_pend_pair);
                end else if (m_pend) begin
                    if (exp_q.size() == DEPTH) m_ovf = 1;
                    else exp_q.push_back(m_pend_pair);
                end else if (pop) begin
                    void'(exp_q.pop_front());
                end
                m_pend = 0;
                if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    model_bit(e.frame, e.din);
                end
            end
        end
        chk("pair_valid", 16'(pair_valid), 16'(exp_q.size() != 0));
        chk("fifo_level", 16'(fifo_level), 16'(exp_q.size()));
        chk("overflow",   16'(overflow),   16'(m_ovf));
        chk("frame_err",  16'(frame_err),  16'(m_ferr));
        if (exp_q.size() != 0) chk("head_pair", {corr_i, corr_q}, exp_q[0]);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(bit f, bit d);
        ssp_frame = f;
        ssp_din   = d;
        ssp_clk   = 1'b1;
        repeat (3) tick();
        ssp_clk = 1'b0;
        // synchroniser (2) + deserialiser edge: lands on the 3rd rising edge
        ev_q.push_back('{due: cyc + 3, frame: f, din: d});
        repeat (3) tick();
    endtask

    task automatic send_byte(logic [7:0] b);
        send_bit(1'b1, b[7]);
        for (int i = 6; i >= 0; i--) send_bit(1'b0, b[i]);
    endtask

    task automatic send_pair(logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        pair_ready = 1'b1;
        tick();
        pair_ready = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        pair_ready = 1'b1;
        while (pair_valid && n < budget) begin
            tick();
            n++;
        end
        pair_ready = 1'b0;
        tick();
        chk("drain_empty", 16'(pair_valid), 16'(0));
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] pairs[5];
    bit          rand_run = 0;

    initial begin
        model_clear();
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 16'(pair_valid), 16'(0));
        chk("rst_level", 16'(fifo_level), 16'(0));
        chk("rst_ovf",   16'(overflow),   16'(0));
        chk("rst_ferr",  16'(frame_err),  16'(0));
        chk("rst_corr",  {corr_i, corr_q}, 16'h0000);
        reset_n = 1'b1;
        tick();

        // 1: 0x7F then 0x81 with ready high: one pair, +127 / -127
        pair_ready = 1'b1;
        send_pair(16'h7F81);
        tick();
        chk("t1_valid", 16'(pair_valid), 16'(1));
        chk("t1_level", 16'(fifo_level), 16'(1));
        chk("t1_pair",  {corr_i, corr_q}, {8'sd127, -8'sd127});
        tick();
        chk("t1_level0", 16'(fifo_level), 16'(0));
        chk("t1_flags", {7'b0, overflow, frame_err}, 16'h0000);
        pair_ready = 1'b0;

        // 2: five pairs into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            pairs[i] = 16'($urandom);
            send_pair(pairs[i]);
        end
        repeat (3) tick();
        chk("t2_level", 16'(fifo_level), 16'(4));
        chk("t2_ovf",   16'(overflow),   16'(1));
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", {corr_i, corr_q}, pairs[i]);
            pop_one();
        end
        tick();
        chk("t2_absent", 16'(pair_valid), 16'(0));

        // 3: frame marker after 3 bits
        pulse_resync();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_pair(16'hA53C);
        tick();
        chk("t3_ferr", 16'(frame_err), 16'(1));
        chk("t3_pair", {corr_i, corr_q}, 16'hA53C);
        pop_one();

        // 4: full FIFO, push and pop on the same edge
        pulse_resync();
        for (int i = 0; i < 4; i++) send_pair(16'($urandom));
        tick();
        chk("t4_full", 16'(fifo_level), 16'(4));
        send_byte(8'h5A);
        send_byte(8'hC3);
        pair_ready = 1'b1;   // seen on the push edge
        tick();
        pair_ready = 1'b0;
        tick();
        chk("t4_level", 16'(fifo_level), 16'(4));
        chk("t4_ovf",   16'(overflow),   16'(0));
        drain(20);

        // 5: resync mid-byte with two pairs queued
        send_pair(16'($urandom));
        send_pair(16'($urandom));
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        pulse_resync();
        chk("t5_level", 16'(fifo_level), 16'(0));
        chk("t5_valid", 16'(pair_valid), 16'(0));
        chk("t5_flags", {7'b0, overflow, frame_err}, 16'h0000);
        send_pair(16'h1122);
        tick();
        chk("t5_pair", {corr_i, corr_q}, 16'h1122);
        pop_one();

        // random traffic: random bytes, random ready, occasional framing errors
        rand_run = 1;
        fork
            begin
                while (rand_run) begin
                    pair_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join_none
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int k = int'($urandom_range(1, 6));
                send_bit(1'b1, 1'($urandom));
                for (int j = 0; j < k; j++) send_bit(1'b0, 1'($urandom));
            end
            send_byte(8'($urandom));
        end
        rand_run = 0;
        tick();
        tick();
        drain(20);
        pulse_resync();

        // 6: reset during the Q byte
        send_byte(8'h44);
        for (int j = 0; j < 4; j++) send_bit(j == 0, 1'($urandom));
        reset_n = 1'b0;
        model_clear();
        tick();
        chk("t6_valid", 16'(pair_valid), 16'(0));
        chk("t6_level", 16'(fifo_level), 16'(0));
        chk("t6_flags", {7'b0, overflow, frame_err}, 16'h0000);
        chk("t6_corr",  {corr_i, corr_q}, 16'h0000);
        reset_n = 1'b1;
        repeat (8) tick();
        chk("t6_nopair", 16'(pair_valid), 16'(0));
        send_pair(16'h807F);
        tick();
        chk("t6_pair", {corr_i, corr_q}, 16'h807F);
        pop_one();

        // 300 framing errors saturate the counter
        for (int j = 0; j < 301; j++) send_bit(1'b1, 1'($urandom));
        tick();
        chk("t6_ferr_sat", 16'(frame_err), 16'(255));

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
